// File: rtl/decoder_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl_pkg
// Description : Shared definitions for the decoder scan controller.
//               - state encoding S_IDLE / S_RUN / S_DONE (2-bit binary)
//               - select code width CODE_W = 2
//               - helpers that compute the first, last and next scan code
//                 for either count direction
// Config      : DECODER_SCAN_DIR_EN (consumed by decoder_scan_ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_scan_ctrl_pkg;

    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [CODE_W-1:0] code_t;

    // Code emitted on the first RUN cycle.
    function automatic code_t code_first(input code_t last, input logic down);
        return down ? last : code_t'(0);
    endfunction

    // Code at which a single pass terminates (on its tick).
    function automatic code_t code_final(input code_t last, input logic down);
        return down ? code_t'(0) : last;
    endfunction

    // Wrapping step within the range 0..last.
    function automatic code_t code_step(input code_t code, input code_t last,
                                        input logic down);
        code_t nxt;
        if (down) begin
            nxt = (code == code_t'(0)) ? last : code - code_t'(1);
        end else begin
            nxt = (code == last) ? code_t'(0) : code + code_t'(1);
        end
        return nxt;
    endfunction

endpackage : decoder_scan_ctrl_pkg
`default_nettype wire

// File: rtl/decoder_scan_ctrl_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running modulo-(DIV_MAX+1) counter with terminal-count
//               strobe. Counts while en is high; clr forces it back to zero.
// Ports       : clk  in  system clock, rising edge
//               rst  in  asynchronous active-high reset
//               clr  in  synchronous clear (takes priority over en)
//               en   in  count enable
//               tc   out high for the cycle in which the counter sits at
//                        DIV_MAX while enabled (wraps on the next edge)
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_MAX   = 49999
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Terminal count is the parameter truncated to the counter width.
    localparam logic [DIV_WIDTH-1:0] c_div_max = DIV_WIDTH'(DIV_MAX);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 w_at_max;

    assign w_at_max = (r_cnt == c_div_max);
    assign tc       = en & w_at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_at_max) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl
// Description : Sequencer driving the select inputs (a = MSB, b = LSB) of a
//               2-to-4 decoder. Steps a 2-bit code 0..LAST_CODE every
//               DIV_MAX+1 clocks, either once (single=1) or continuously.
// Ports       : clk     in  system clock, rising edge
//               rst     in  asynchronous active-high reset
//               start   in  begins a scan when idle (level sampled)
//               stop    in  aborts a scan, wins over start and tick
//               single  in  sampled with start: 1 = one pass, 0 = continuous
//               dir     in  (DECODER_SCAN_DIR_EN only) sampled with start:
//                           1 = count down from LAST_CODE
//               a, b    out registered decoder selects (code[1], code[0])
//               tick    out one-cycle pulse on the edge the code advances
//               busy    out high while scanning
//               done    out one-cycle pulse at the end of a single pass
// Config      : `define DECODER_SCAN_DIR_EN adds the dir input and the
//               down-count mode; without it the scan counts up only.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_MAX   = 49999,
    parameter int LAST_CODE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic single,
`ifdef DECODER_SCAN_DIR_EN
    input  logic dir,
`endif
    output logic a,
    output logic b,
    output logic tick,
    output logic busy,
    output logic done
);

    localparam code_t c_last = code_t'(LAST_CODE);

    state_t r_state;
    state_t w_state_nx;
    code_t  r_code;
    code_t  w_code_nx;
    logic   r_single;
    logic   w_single_nx;
    logic   r_down;
    logic   w_down_nx;
    logic   w_dir_in;
    logic   w_en;
    logic   w_clr;
    logic   w_tc;
    logic   w_tick_nx;
    logic   r_tick;
    logic   r_busy;
    logic   r_done;

`ifdef DECODER_SCAN_DIR_EN
    assign w_dir_in = dir;
`else
    assign w_dir_in = 1'b0;
`endif

    // The prescaler only runs in RUN and is held cleared everywhere else, so
    // every scan starts from a fresh count. Gating en with stop keeps a stop
    // that coincides with the terminal count from producing a tick.
    assign w_en  = (r_state == S_RUN) && !stop;
    assign w_clr = !w_en;

    tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en),
        .tc  (w_tc)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state, next code and next output values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_code_nx   = r_code;
        w_single_nx = r_single;
        w_down_nx   = r_down;
        w_tick_nx   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_code_nx = '0;
                if (start && !stop) begin
                    w_state_nx  = S_RUN;
                    w_single_nx = single;
                    w_down_nx   = w_dir_in;
                    w_code_nx   = code_first(c_last, w_dir_in);
                end
            end

            S_RUN: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                    w_code_nx  = '0;
                end else if (w_tc) begin
                    w_tick_nx = 1'b1;
                    if (r_single && (r_code == code_final(c_last, r_down))) begin
                        w_state_nx = S_DONE;
                        w_code_nx  = '0;
                    end else begin
                        w_code_nx = code_step(r_code, c_last, r_down);
                    end
                end
            end

            S_DONE: begin
                w_state_nx = S_IDLE;
                w_code_nx  = '0;
            end

            default: begin
                w_state_nx = S_IDLE;
                w_code_nx  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Code, mode latches and registered outputs. busy/done are derived from
    // the next state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code   <= '0;
            r_single <= 1'b0;
            r_down   <= 1'b0;
            r_tick   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_code   <= w_code_nx;
            r_single <= w_single_nx;
            r_down   <= w_down_nx;
            r_tick   <= w_tick_nx;
            r_busy   <= (w_state_nx == S_RUN);
            r_done   <= (w_state_nx == S_DONE);
        end
    end

    assign a    = r_code[1];
    assign b    = r_code[0];
    assign tick = r_tick;
    assign busy = r_busy;
    assign done = r_done;

endmodule : decoder_scan_ctrl
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan_ctrl
// Description : Directed self-checking bench for decoder_scan_ctrl with
//               DIV_MAX=3, LAST_CODE=3. Outputs are sampled on the falling
//               edge; a 2-to-4 decoder model checks the end-to-end one-hot.
// Config      : DECODER_SCAN_DIR_EN enables the down-count pass.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_ctrl;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_MAX   = 3;
    localparam int LAST_CODE = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic stop;
    logic single;
`ifdef DECODER_SCAN_DIR_EN
    logic dir;
`endif
    logic a;
    logic b;
    logic tick;
    logic busy;
    logic done;

    int n_tests = 0;
    int n_fail  = 0;

    decoder_scan_ctrl #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX),
        .LAST_CODE (LAST_CODE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .single (single),
`ifdef DECODER_SCAN_DIR_EN
        .dir    (dir),
`endif
        .a      (a),
        .b      (b),
        .tick   (tick),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Downstream 2-to-4 decoder: y1 (bit 0) for select 00 ... y4 (bit 3) for 11.
    function automatic logic [3:0] dec2to4(input logic sa, input logic sb);
        logic [3:0] y;
        case ({sa, sb})
            2'b00:   y = 4'b0001;
            2'b01:   y = 4'b0010;
            2'b10:   y = 4'b0100;
            default: y = 4'b1000;
        endcase
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s_ab", tag),   {30'd0, a, b}, 32'd0);
        chk($sformatf("%s_tick", tag), {31'd0, tick}, 32'd0);
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s_done", tag), {31'd0, done}, 32'd0);
    endtask

    // Expectation for the k-th falling edge after start was sampled
    // (k = 0 is the cycle right after the sampling edge).
    task automatic chk_run(input string tag, input int k, input bit down);
        logic [1:0] c;
        logic [3:0] y_exp;
        c = 2'((k / 4) % 4);
        if (down) c = 2'd3 - c;
        y_exp = 4'b0001 << c;
        chk($sformatf("%s_ab_k%0d", tag, k),   {30'd0, a, b}, {30'd0, c});
        chk($sformatf("%s_tick_k%0d", tag, k), {31'd0, tick},
            {31'd0, (k > 0) && (k % 4 == 0)});
        chk($sformatf("%s_busy_k%0d", tag, k), {31'd0, busy}, 32'd1);
        chk($sformatf("%s_done_k%0d", tag, k), {31'd0, done}, 32'd0);
        chk($sformatf("%s_y_k%0d", tag, k),    {28'd0, dec2to4(a, b)}, {28'd0, y_exp});
    endtask

    // Called on a falling edge; returns on the falling edge after start was sampled.
    task automatic pulse_start(input bit s);
        start  = 1'b1;
        single = s;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        single = 1'b0;
`ifdef DECODER_SCAN_DIR_EN
        dir    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // Continuous scan: 00,01,10,11,00 for 4 clocks each
        pulse_start(1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            chk_run("cont", k, 1'b0);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_idle("cont_stop");

        // Single pass: 16 clocks of codes, then done for one cycle
        pulse_start(1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            chk_run("single", k, 1'b0);
        end
        @(negedge clk);
        chk("single_end_ab",   {30'd0, a, b}, 32'd0);
        chk("single_end_done", {31'd0, done}, 32'd1);
        chk("single_end_busy", {31'd0, busy}, 32'd0);
        chk("single_end_tick", {31'd0, tick}, 32'd1);
        @(negedge clk);
        chk_idle("single_after");
        repeat (5) @(negedge clk);
        chk_idle("single_stays_idle");

        // Stop at code 10 on the edge where the tick would occur
        pulse_start(1'b0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk_run("stoptick", k, 1'b0);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_idle("stoptick_stop");
        @(negedge clk);
        chk_idle("stoptick_hold");

        // start and stop together in IDLE: stay idle
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("start_stop");
        @(negedge clk);
        chk_idle("start_stop_hold");

        // start pulses during RUN leave code and tick timing unchanged
        pulse_start(1'b0);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            start = 1'b0;
            chk_run("midstart", k, 1'b0);
            if (k == 5 || k == 8 || k == 11) start = 1'b1;
        end
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        chk_idle("midstart_stop");

        // Asynchronous reset while code 11 is showing
        pulse_start(1'b0);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            chk_run("arst", k, 1'b0);
        end
        #2 rst = 1'b1;
        #1 chk_idle("arst_async");
        @(negedge clk);
        rst = 1'b0;
        chk_idle("arst_release");
        repeat (6) @(negedge clk);
        chk_idle("arst_idle");

`ifdef DECODER_SCAN_DIR_EN
        // Down-count single pass: 11,10,01,00 then done
        dir = 1'b1;
        pulse_start(1'b1);
        dir = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            chk_run("down", k, 1'b1);
        end
        @(negedge clk);
        chk("down_end_ab",   {30'd0, a, b}, 32'd0);
        chk("down_end_done", {31'd0, done}, 32'd1);
        chk("down_end_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk_idle("down_after");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decoder_scan_ctrl
`default_nettype wire
